// File: rtl/half_duplex_pio.sv
// Half-duplex single-wire programmed-IO master: shifts a frame out LSB first, releases the pad,
// then optionally samples a response frame mid-slot and presents it with a one-cycle valid pulse.
module half_duplex_pio #(
  parameter int WIDTH       = 8,
  parameter int BIT_CYCLES  = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             TX_VALID,
  output logic             TX_READY,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_READ,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             BUSY,
  output logic             PAD_I,
  output logic             PAD_T,
  input  logic             PAD_O
);

  localparam int CNT_MAX = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
  localparam int SLOT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_MID  = SLOT_W'(BIT_CYCLES / 2);
  localparam logic [SLOT_W-1:0] TURN_LAST = SLOT_W'(TURN_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TX   = 2'd1,
    S_TURN = 2'd2,
    S_RX   = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [SLOT_W-1:0] slot_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WIDTH-1:0]  tx_shift;
  logic              tx_read_q;
  logic [WIDTH-1:0]  rx_shift;
  logic [WIDTH-1:0]  rx_shift_d;
  logic [WIDTH-1:0]  rx_data_q;
  logic              rx_valid_q;
  logic              rx_done;
  logic              pad_t_q;
  logic              pad_t_d;
  logic              pad_i_q;
  logic              pad_i_d;
  logic              slot_last;
  logic              bit_last;
  logic              turn_last;
  logic              accept;

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign turn_last = (slot_cnt == TURN_LAST);
  assign accept    = (state_q == S_IDLE) && TX_VALID;

  assign TX_READY = (state_q == S_IDLE);
  assign BUSY     = (state_q != S_IDLE);
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign PAD_T    = pad_t_q;
  assign PAD_I    = pad_i_q;

  // State, counters, frame registers and registered pad drivers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      slot_cnt   <= '0;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      tx_read_q  <= 1'b0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      pad_t_q    <= 1'b1;
      pad_i_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pad_t_q    <= pad_t_d;
      pad_i_q    <= pad_i_d;
      rx_valid_q <= rx_done;
      rx_shift   <= rx_shift_d;
      if (rx_done) begin
        rx_data_q <= rx_shift_d;
      end

      // Bit 0 goes straight to the pad register; the shifter holds the remaining bits
      if (accept) begin
        tx_shift  <= TX_DATA >> 1;
        tx_read_q <= TX_READ;
      end else if ((state_q == S_TX) && slot_last) begin
        tx_shift <= tx_shift >> 1;
      end

      if (state_d != state_q) begin
        slot_cnt <= '0;
        bit_cnt  <= '0;
      end else if ((state_q == S_TX) || (state_q == S_RX)) begin
        if (slot_last) begin
          slot_cnt <= '0;
          bit_cnt  <= bit_cnt + 1'b1;
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
        end
      end else if (state_q == S_TURN) begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (TX_VALID) state_d = S_TX;
      S_TX:   if (slot_last && bit_last) state_d = S_TURN;
      S_TURN: if (turn_last) state_d = tx_read_q ? S_RX : S_IDLE;
      S_RX:   if (slot_last && bit_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pad values are computed for the upcoming state so the registered pins line up with it
  always_comb begin
    pad_t_d    = (state_d != S_TX);
    pad_i_d    = 1'b0;
    rx_shift_d = rx_shift;
    rx_done    = (state_q == S_RX) && (state_d == S_IDLE);
    if (state_d == S_TX) begin
      if (state_q == S_IDLE) begin
        pad_i_d = TX_DATA[0];
      end else if (slot_last) begin
        pad_i_d = tx_shift[0];
      end else begin
        pad_i_d = pad_i_q;
      end
    end
    if ((state_q == S_RX) && (slot_cnt == SLOT_MID)) begin
      rx_shift_d[bit_cnt] = PAD_O;
    end
  end

endmodule

// File: tb/tb_half_duplex_pio.sv
// Bench for half_duplex_pio: random frames, glitching responder and mid-frame reset,
// checked cycle by cycle against an expected pad/handshake timeline built from the frame timing rules.
module tb_half_duplex_pio;
  localparam int W = 8;
  localparam int B = 4;
  localparam int T = 2;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic         TX_VALID = 1'b0;
  logic         TX_READ = 1'b0;
  logic [W-1:0] TX_DATA = '0;
  logic         PAD_O = 1'b0;
  logic         TX_READY;
  logic         RX_VALID;
  logic         BUSY;
  logic         PAD_I;
  logic         PAD_T;
  logic [W-1:0] RX_DATA;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_rx = '0;

  half_duplex_pio #(.WIDTH(W), .BIT_CYCLES(B), .TURN_CYCLES(T)) dut (
    .CLK(CLK), .RSTN(RSTN), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .TX_DATA(TX_DATA), .TX_READ(TX_READ), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .BUSY(BUSY), .PAD_I(PAD_I), .PAD_T(PAD_T), .PAD_O(PAD_O)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // One transfer from the acceptance cycle (cycle 0) through its first IDLE cycle.
  // glitch: 0 = random PAD_O off the sample cycle, 1 = complement of the bit off the sample cycle.
  task automatic run_txn(input logic [W-1:0] data, input logic rd, input logic [W-1:0] resp,
                         input int glitch, input bit hold, input bit start_now);
    int           lat;
    int           r;
    logic [W+4:0] actv;
    logic [W+4:0] expv;
    logic [W-1:0] prev_rx;
    lat     = 1 + W*B + T + (rd ? W*B : 0);
    prev_rx = exp_rx;
    if (!start_now) @(negedge CLK);
    TX_VALID = 1'b1;
    TX_DATA  = data;
    TX_READ  = rd;
    n_checks++;
    if (TX_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: TX_READY=%b expected 1", TX_READY);
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge CLK);
      TX_DATA  = W'($urandom);
      TX_READ  = 1'($urandom_range(0, 1));
      TX_VALID = hold ? 1'b1 : ((c < lat) ? 1'($urandom_range(0, 1)) : 1'b0);
      r = c - (W*B + T) - 1;
      if (rd && (r >= 0) && (r < W*B)) begin
        if ((r % B) == (B / 2))  PAD_O = resp[r / B];
        else if (glitch == 1)    PAD_O = ~resp[r / B];
        else                     PAD_O = 1'($urandom_range(0, 1));
      end else begin
        PAD_O = 1'($urandom_range(0, 1));
      end
      expv[W+4]   = (c > W*B);
      expv[W+3]   = (c <= W*B) ? data[(c - 1) / B] : 1'b0;
      expv[W+2]   = (c < lat);
      expv[W+1]   = rd && (c == lat);
      expv[W]     = (c == lat);
      expv[W-1:0] = (rd && (c == lat)) ? resp : prev_rx;
      actv = {PAD_T, PAD_I, BUSY, RX_VALID, TX_READY, RX_DATA};
      n_checks++;
      if (actv !== expv) begin
        n_fail++;
        $display("FAIL txn_cycle data=%h rd=%b cycle=%0d: {pad_t,pad_i,busy,rx_valid,tx_ready,rx_data} got %b_%h expected %b_%h",
                 data, rd, c, actv[W+4:W], actv[W-1:0], expv[W+4:W], expv[W-1:0]);
      end
    end
    if (rd) exp_rx = resp;
  endtask

  task automatic test_reset;
    logic [W+4:0] actv;
    RSTN = 1'b0;
    #12;
    actv = {PAD_T, PAD_I, BUSY, RX_VALID, TX_READY, RX_DATA};
    n_checks++;
    if (actv !== {5'b10001, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: got %b_%h expected 10001_00", actv[W+4:W], actv[W-1:0]);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    exp_rx = '0;
  endtask

  task automatic test_write;
    run_txn(8'hA5, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_txn(W'($urandom), 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read;
    run_txn(8'h3C, 1'b1, 8'h96, 1, 1'b0, 1'b0);
    run_txn(8'h3C, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    run_txn(W'($urandom), 1'b1, 8'hFF, 1, 1'b0, 1'b0);
    run_txn(W'($urandom), 1'b1, 8'h00, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_txn(W'($urandom), 1'b1, W'($urandom), int'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_txn(W'($urandom), 1'b1, W'($urandom), 0, 1'b1, 1'b0);
    run_txn(W'($urandom), 1'b1, W'($urandom), 1, 1'b1, 1'b1);
    run_txn(W'($urandom), 1'b0, 8'h00, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_tx;
    logic [W+4:0] actv;
    @(negedge CLK);
    TX_VALID = 1'b1;
    TX_DATA  = W'($urandom);
    TX_READ  = 1'b1;
    for (int c = 1; c <= 3*B + 2; c++) begin
      @(negedge CLK);
      TX_VALID = 1'b0;
    end
    n_checks++;
    if (PAD_T !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_tx_drive: PAD_T=%b expected 0", PAD_T);
    end
    #1 RSTN = 1'b0;
    #1;
    actv = {PAD_T, PAD_I, BUSY, RX_VALID, TX_READY, RX_DATA};
    n_checks++;
    if (actv !== {5'b10001, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL async_reset: got %b_%h expected 10001_00", actv[W+4:W], actv[W-1:0]);
    end
    repeat (2) @(negedge CLK);
    RSTN   = 1'b1;
    exp_rx = '0;
    run_txn(8'hA5, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({BUSY, RX_VALID, RX_DATA} !== {2'b00, {W{1'b0}}}) begin
        n_fail++;
        $display("FAIL post_reset_quiet: busy=%b rx_valid=%b rx_data=%h expected 0 0 00", BUSY, RX_VALID, RX_DATA);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_mid_tx;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
